// File: rtl/mem_arbiter_if.sv
// Purpose: CPU + debug/loader request bundle between requesters and mem_arbiter.
// Latency: n/a (wiring only); grants combinational, read data one cycle after grant.
// Backpressure: requester holds req until gnt; cpu_stall tells the CPU to freeze.
// Ports (per requester): req/we/addr/wdata in, gnt/rdata/rvalid out;
//   CPU also gets cpu_stall, debug drives dbg_lock, lock_active reports LOCK.
interface mem_arbiter_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_rvalid;
  logic              cpu_stall;

  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_lock;
  logic              dbg_gnt;
  logic [DATA_W-1:0] dbg_rdata;
  logic              dbg_rvalid;

  logic              lock_active;

  // Requester side (CPU pipeline and debug loader).
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rdata, cpu_rvalid, cpu_stall,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
    input  dbg_gnt, dbg_rdata, dbg_rvalid,
    input  lock_active
  );

  // Arbiter side.
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rdata, cpu_rvalid, cpu_stall,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
    output dbg_gnt, dbg_rdata, dbg_rvalid,
    output lock_active
  );
endinterface

// File: rtl/mem_arbiter.sv
// Purpose: single-port RAM shared by CPU and debug port; CPU priority with anti-starvation, debug lock.
// Latency: grant combinational, write at the grant edge, read data/rvalid one cycle after grant.
// Backpressure: losing requester holds its request; CPU sees cpu_stall while denied or locked out.
// Ports: clk, reset (async active-low), bus (mem_arbiter_if.slave: both request ports,
//   grants, read data/valid, cpu_stall, dbg_lock, lock_active).
module mem_arbiter #(
  parameter int ADDR_W       = 4,
  parameter int DATA_W       = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  typedef enum logic {SHARED, LOCK} state_t;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  state_t            state;
  logic [3:0]        starve_cnt;
  logic              lock_q;
  logic              cpu_rvalid_q, dbg_rvalid_q;
  logic [DATA_W-1:0] cpu_rdata_q, dbg_rdata_q;

  logic              cpu_gnt_c, dbg_gnt_c, cpu_stall_c, lock_nxt;
  logic              acc_we;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Grants are held off while reset is asserted so nothing touches the RAM.
  always_comb begin
    cpu_gnt_c   = 1'b0;
    dbg_gnt_c   = 1'b0;
    cpu_stall_c = 1'b0;
    if (reset) begin
      if (state == LOCK) begin
        dbg_gnt_c = bus.dbg_req;
      end else if (bus.cpu_req && bus.dbg_req) begin
        // CPU wins contention until debug has been denied STARVE_LIMIT times.
        if (starve_cnt == STARVE_MAX) dbg_gnt_c = 1'b1;
        else                          cpu_gnt_c = 1'b1;
      end else begin
        cpu_gnt_c = bus.cpu_req;
        dbg_gnt_c = bus.dbg_req;
      end
    end
    if (state == LOCK) cpu_stall_c = 1'b1;
    else               cpu_stall_c = bus.cpu_req & ~cpu_gnt_c;
  end

  always_comb begin
    lock_nxt = 1'b0;
    if (state == LOCK) lock_nxt = bus.dbg_lock;
    else               lock_nxt = dbg_gnt_c & bus.dbg_lock;
  end

  // Single access port: the granted requester drives it.
  always_comb begin
    acc_we    = cpu_gnt_c & bus.cpu_we;
    acc_addr  = bus.cpu_addr;
    acc_wdata = bus.cpu_wdata;
    if (dbg_gnt_c) begin
      acc_we    = bus.dbg_we;
      acc_addr  = bus.dbg_addr;
      acc_wdata = bus.dbg_wdata;
    end
  end

  // RAM has no reset: contents survive reset assertion.
  always_ff @(posedge clk) begin
    if (acc_we) mem[acc_addr] <= acc_wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= SHARED;
      starve_cnt   <= 4'd0;
      lock_q       <= 1'b0;
      cpu_rvalid_q <= 1'b0;
      dbg_rvalid_q <= 1'b0;
      cpu_rdata_q  <= '0;
      dbg_rdata_q  <= '0;
    end else begin
      state  <= lock_nxt ? LOCK : SHARED;
      lock_q <= lock_nxt;

      // Counts only debug denials caused by CPU contention.
      if (dbg_gnt_c || !bus.dbg_req) starve_cnt <= 4'd0;
      else if (cpu_gnt_c)            starve_cnt <= starve_cnt + 4'd1;

      cpu_rvalid_q <= cpu_gnt_c & ~bus.cpu_we;
      dbg_rvalid_q <= dbg_gnt_c & ~bus.dbg_we;
      if (cpu_gnt_c && !bus.cpu_we) cpu_rdata_q <= mem[acc_addr];
      if (dbg_gnt_c && !bus.dbg_we) dbg_rdata_q <= mem[acc_addr];
    end
  end

  assign bus.cpu_gnt     = cpu_gnt_c;
  assign bus.dbg_gnt     = dbg_gnt_c;
  assign bus.cpu_stall   = cpu_stall_c;
  assign bus.cpu_rvalid  = cpu_rvalid_q;
  assign bus.dbg_rvalid  = dbg_rvalid_q;
  assign bus.cpu_rdata   = cpu_rdata_q;
  assign bus.dbg_rdata   = dbg_rdata_q;
  assign bus.lock_active = lock_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Purpose: self-checking bench for mem_arbiter (directed vectors plus modelled random traffic).
// Latency: inputs change 1ns after each rising edge, outputs checked 1-2ns after.
// Backpressure: requests are held/dropped by the bench directly, no flow control.
module tb_mem_arbiter;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;

  mem_arbiter_if #(.ADDR_W(4), .DATA_W(8)) bus ();

  mem_arbiter #(.ADDR_W(4), .DATA_W(8), .STARVE_LIMIT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cpu(input logic r, input logic w, input logic [3:0] a, input logic [7:0] d);
    bus.cpu_req   = r;
    bus.cpu_we    = w;
    bus.cpu_addr  = a;
    bus.cpu_wdata = d;
  endtask

  task automatic drive_dbg(input logic r, input logic w, input logic [3:0] a, input logic [7:0] d,
                           input logic l);
    bus.dbg_req   = r;
    bus.dbg_we    = w;
    bus.dbg_addr  = a;
    bus.dbg_wdata = d;
    bus.dbg_lock  = l;
  endtask

  task automatic idle();
    drive_cpu(1'b0, 1'b0, 4'd0, 8'd0);
    drive_dbg(1'b0, 1'b0, 4'd0, 8'd0, 1'b0);
  endtask

  logic [7:0] ref_mem [16];

  initial begin
    n_chk  = 0;
    n_fail = 0;
    reset  = 1'b0;
    idle();

    // Reset state, and no grant while reset is held.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cpu_rvalid", bus.cpu_rvalid, 0);
    chk("rst_dbg_rvalid", bus.dbg_rvalid, 0);
    chk("rst_cpu_rdata", bus.cpu_rdata, 0);
    chk("rst_dbg_rdata", bus.dbg_rdata, 0);
    chk("rst_lock_active", bus.lock_active, 0);
    drive_cpu(1'b1, 1'b0, 4'd0, 8'd0);
    #1;
    chk("rst_no_gnt", bus.cpu_gnt, 0);
    idle();
    step();
    reset = 1'b1;

    // CPU write 3 = A5, read it back.
    drive_cpu(1'b1, 1'b1, 4'd3, 8'hA5);
    #1;
    chk("wr_cpu_gnt", bus.cpu_gnt, 1);
    chk("wr_dbg_gnt", bus.dbg_gnt, 0);
    chk("wr_stall", bus.cpu_stall, 0);
    step();
    chk("wr_no_rvalid", bus.cpu_rvalid, 0);
    drive_cpu(1'b1, 1'b0, 4'd3, 8'h00);
    #1;
    chk("rd_cpu_gnt", bus.cpu_gnt, 1);
    step();
    chk("rd_rvalid", bus.cpu_rvalid, 1);
    chk("rd_rdata", bus.cpu_rdata, 8'hA5);
    chk("rd_dbg_rvalid", bus.dbg_rvalid, 0);
    idle();
    step();
    chk("rd_rvalid_pulse", bus.cpu_rvalid, 0);
    chk("rd_rdata_hold", bus.cpu_rdata, 8'hA5);

    // Contention: CPU x4, debug 5th with cpu_stall, repeating.
    drive_cpu(1'b1, 1'b0, 4'd3, 8'h00);
    drive_dbg(1'b1, 1'b0, 4'd3, 8'h00, 1'b0);
    for (int i = 0; i < 10; i++) begin
      logic exp_d;
      exp_d = ((i % 5) == 4);
      #1;
      chk($sformatf("starve_cpu_gnt[%0d]", i), bus.cpu_gnt, !exp_d);
      chk($sformatf("starve_dbg_gnt[%0d]", i), bus.dbg_gnt, exp_d);
      chk($sformatf("starve_stall[%0d]", i), bus.cpu_stall, exp_d);
      step();
      chk($sformatf("starve_cpu_rvalid[%0d]", i), bus.cpu_rvalid, !exp_d);
      chk($sformatf("starve_dbg_rvalid[%0d]", i), bus.dbg_rvalid, exp_d);
      if (exp_d) chk($sformatf("starve_dbg_rdata[%0d]", i), bus.dbg_rdata, 8'hA5);
    end
    idle();
    step();

    // Locked burst load of addr i = i while the CPU keeps requesting.
    for (int i = 0; i < 16; i++) begin
      drive_dbg(1'b1, 1'b1, 4'(i), 8'(i), 1'b1);
      drive_cpu(i != 0, 1'b0, 4'd7, 8'h00);
      #1;
      chk($sformatf("lock_dbg_gnt[%0d]", i), bus.dbg_gnt, 1);
      chk($sformatf("lock_cpu_gnt[%0d]", i), bus.cpu_gnt, 0);
      if (i != 0) begin
        chk($sformatf("lock_stall[%0d]", i), bus.cpu_stall, 1);
        chk($sformatf("lock_active[%0d]", i), bus.lock_active, 1);
      end
      step();
    end
    // Lock drops; the debug read in this same cycle is still granted.
    drive_dbg(1'b1, 1'b0, 4'd15, 8'h00, 1'b0);
    drive_cpu(1'b1, 1'b0, 4'd7, 8'h00);
    #1;
    chk("unlock_dbg_gnt", bus.dbg_gnt, 1);
    chk("unlock_cpu_gnt", bus.cpu_gnt, 0);
    chk("unlock_stall", bus.cpu_stall, 1);
    chk("unlock_active_still", bus.lock_active, 1);
    step();
    chk("unlock_active", bus.lock_active, 0);
    chk("unlock_dbg_rvalid", bus.dbg_rvalid, 1);
    chk("unlock_dbg_rdata", bus.dbg_rdata, 8'h0F);
    drive_dbg(1'b0, 1'b0, 4'd0, 8'h00, 1'b0);
    for (int j = 0; j < 16; j++) begin
      drive_cpu(1'b1, 1'b0, 4'(j), 8'h00);
      #1;
      chk($sformatf("rb_cpu_gnt[%0d]", j), bus.cpu_gnt, 1);
      step();
      chk($sformatf("rb_rvalid[%0d]", j), bus.cpu_rvalid, 1);
      chk($sformatf("rb_rdata[%0d]", j), bus.cpu_rdata, j);
    end
    idle();
    step();

    // Debug write 15 = 01 then immediate read-after-write.
    drive_dbg(1'b1, 1'b1, 4'd15, 8'h01, 1'b0);
    #1;
    chk("raw_wr_gnt", bus.dbg_gnt, 1);
    step();
    drive_dbg(1'b1, 1'b0, 4'd15, 8'h00, 1'b0);
    #1;
    chk("raw_rd_gnt", bus.dbg_gnt, 1);
    step();
    chk("raw_rvalid", bus.dbg_rvalid, 1);
    chk("raw_rdata", bus.dbg_rdata, 8'h01);
    idle();
    step();

    // Reset mid-LOCK with a granted read not yet taken.
    drive_dbg(1'b1, 1'b1, 4'd2, 8'h5A, 1'b1);
    #1;
    step();
    chk("rl_lock_active", bus.lock_active, 1);
    drive_dbg(1'b1, 1'b0, 4'd2, 8'h00, 1'b1);
    #1;
    chk("rl_rd_gnt", bus.dbg_gnt, 1);
    reset = 1'b0;
    drive_dbg(1'b1, 1'b1, 4'd2, 8'hFF, 1'b1);
    #1;
    chk("rl_gnt_gone", bus.dbg_gnt, 0);
    chk("rl_lock_cleared", bus.lock_active, 0);
    chk("rl_dbg_rdata", bus.dbg_rdata, 0);
    step();
    chk("rl_no_rvalid", bus.dbg_rvalid, 0);
    idle();
    reset = 1'b1;
    drive_cpu(1'b1, 1'b0, 4'd2, 8'h00);
    #1;
    chk("rl_shared_cpu_gnt", bus.cpu_gnt, 1);
    step();
    chk("rl_mem2_rvalid", bus.cpu_rvalid, 1);
    chk("rl_mem2_intact", bus.cpu_rdata, 8'h5A);
    drive_cpu(1'b1, 1'b0, 4'd15, 8'h00);
    step();
    chk("rl_mem15_intact", bus.cpu_rdata, 8'h01);
    idle();
    step();

    // Random concurrent traffic against a reference arbiter + memory.
    for (int k = 0; k < 16; k++) ref_mem[k] = 8'(k);
    ref_mem[15] = 8'h01;
    ref_mem[2]  = 8'h5A;
    begin
      logic       m_lock, eg_c, eg_d, es;
      logic [3:0] m_cnt;
      logic       pend_c, pend_d;
      logic [7:0] exp_c, exp_d;
      logic       cq, cw, dq, dw, dl;
      logic [3:0] ca, da;
      logic [7:0] cd, dd;
      m_lock = 1'b0;
      m_cnt  = 4'd0;
      for (int n = 0; n < 300; n++) begin
        cq = ($urandom_range(0, 3) != 0);
        cw = $urandom_range(0, 1) != 0;
        ca = 4'($urandom_range(0, 15));
        cd = 8'($urandom_range(0, 255));
        dq = $urandom_range(0, 1) != 0;
        dw = $urandom_range(0, 1) != 0;
        da = 4'($urandom_range(0, 15));
        dd = 8'($urandom_range(0, 255));
        dl = ($urandom_range(0, 3) == 0);
        drive_cpu(cq, cw, ca, cd);
        drive_dbg(dq, dw, da, dd, dl);

        eg_c = 1'b0;
        eg_d = 1'b0;
        if (m_lock) begin
          eg_d = dq;
          es   = 1'b1;
        end else begin
          if (cq && dq) begin
            if (m_cnt == 4'd4) eg_d = 1'b1;
            else               eg_c = 1'b1;
          end else begin
            eg_c = cq;
            eg_d = dq;
          end
          es = cq && !eg_c;
        end
        #1;
        chk("rnd_cpu_gnt", bus.cpu_gnt, eg_c);
        chk("rnd_dbg_gnt", bus.dbg_gnt, eg_d);
        chk("rnd_stall", bus.cpu_stall, es);
        chk("rnd_overlap", bus.cpu_gnt & bus.dbg_gnt, 0);

        pend_c = eg_c && !cw;
        pend_d = eg_d && !dw;
        exp_c  = ref_mem[ca];
        exp_d  = ref_mem[da];
        if (eg_c && cw) ref_mem[ca] = cd;
        if (eg_d && dw) ref_mem[da] = dd;
        if (eg_d || !dq)            m_cnt = 4'd0;
        else if (eg_c)              m_cnt = m_cnt + 4'd1;
        if (m_lock) m_lock = dl;
        else        m_lock = eg_d && dl;

        step();
        chk("rnd_cpu_rvalid", bus.cpu_rvalid, pend_c);
        chk("rnd_dbg_rvalid", bus.dbg_rvalid, pend_d);
        if (pend_c) chk("rnd_cpu_rdata", bus.cpu_rdata, exp_c);
        if (pend_d) chk("rnd_dbg_rdata", bus.dbg_rdata, exp_d);
        chk("rnd_lock_active", bus.lock_active, m_lock);
      end
    end
    idle();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
